// File: rtl/reg_scoreboard_if.sv
// Issue, writeback, flush and status signals between the scheduler and the register scoreboard.
// The scheduler drives through the master modport; the scoreboard uses the slave modport.
interface reg_scoreboard_if;
  logic        issue_valid;
  logic [5:0]  issue_rd_rn;
  logic [5:0]  issue_rd2_rn;

  logic        wb_alu1_valid;
  logic [5:0]  wb_alu1_rn;
  logic        wb_alu2_valid;
  logic [5:0]  wb_alu2_rn;
  logic        wb_memunit_valid;
  logic [5:0]  wb_memunit_rn;
  logic        wb_branch_valid;
  logic [5:0]  wb_branch_rn;
  logic        wb_advint_valid;
  logic [5:0]  wb_advint_rn;
  logic        wb_advint2_valid;
  logic [5:0]  wb_advint2_rn;

  logic        flush;

  logic [63:0] reg_busy;
  logic [6:0]  busy_count;
  logic        idle;
  logic        wb_error;

  modport master (
    output issue_valid, issue_rd_rn, issue_rd2_rn,
    output wb_alu1_valid, wb_alu1_rn, wb_alu2_valid, wb_alu2_rn,
    output wb_memunit_valid, wb_memunit_rn, wb_branch_valid, wb_branch_rn,
    output wb_advint_valid, wb_advint_rn, wb_advint2_valid, wb_advint2_rn,
    output flush,
    input  reg_busy, busy_count, idle, wb_error
  );

  modport slave (
    input  issue_valid, issue_rd_rn, issue_rd2_rn,
    input  wb_alu1_valid, wb_alu1_rn, wb_alu2_valid, wb_alu2_rn,
    input  wb_memunit_valid, wb_memunit_rn, wb_branch_valid, wb_branch_rn,
    input  wb_advint_valid, wb_advint_rn, wb_advint2_valid, wb_advint2_rn,
    input  flush,
    output reg_busy, busy_count, idle, wb_error
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: one pending-write bit per architectural register, set at issue, cleared at writeback.
// reg_busy reflects same-cycle issues with zero latency; writeback clears become visible one cycle later. No backpressure.
module reg_scoreboard #(
  parameter bit R0_HARDWIRED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  reg_scoreboard_if.slave   sb
);

  localparam int NUM_WB = 6;

  logic [63:0] busy_q, busy_d;
  logic        wb_error_q, wb_error_d;

  logic [63:0] issue_set;
  logic [63:0] wb_clr;
  logic        wb_err_now;
  logic [6:0]  busy_cnt;

  logic             wb_vld [NUM_WB];
  logic [5:0]       wb_rn  [NUM_WB];

  always_comb begin
    wb_vld[0] = sb.wb_alu1_valid;    wb_rn[0] = sb.wb_alu1_rn;
    wb_vld[1] = sb.wb_alu2_valid;    wb_rn[1] = sb.wb_alu2_rn;
    wb_vld[2] = sb.wb_memunit_valid; wb_rn[2] = sb.wb_memunit_rn;
    wb_vld[3] = sb.wb_branch_valid;  wb_rn[3] = sb.wb_branch_rn;
    wb_vld[4] = sb.wb_advint_valid;  wb_rn[4] = sb.wb_advint_rn;
    wb_vld[5] = sb.wb_advint2_valid; wb_rn[5] = sb.wb_advint2_rn;
  end

  // Secondary destination 0 means "no second writer", independent of R0_HARDWIRED.
  always_comb begin
    issue_set = '0;
    if (sb.issue_valid) begin
      issue_set[sb.issue_rd_rn] = 1'b1;
      if (sb.issue_rd2_rn != 6'd0) begin
        issue_set[sb.issue_rd2_rn] = 1'b1;
      end
    end
    if (R0_HARDWIRED) begin
      issue_set[0] = 1'b0;
    end
  end

  // Duplicate targets across ports simply OR into the same clear bit.
  always_comb begin
    wb_clr = '0;
    for (int i = 0; i < NUM_WB; i++) begin
      if (wb_vld[i]) begin
        wb_clr[wb_rn[i]] = 1'b1;
      end
    end
    if (R0_HARDWIRED) begin
      wb_clr[0] = 1'b0;
    end
  end

  // A writeback is legitimate if the register is already pending or is being claimed this cycle.
  always_comb begin
    wb_err_now = 1'b0;
    for (int i = 0; i < NUM_WB; i++) begin
      if (wb_vld[i] && (wb_rn[i] != 6'd0) &&
          !busy_q[wb_rn[i]] && !issue_set[wb_rn[i]]) begin
        wb_err_now = 1'b1;
      end
    end
  end

  always_comb begin
    busy_d     = (busy_q & ~wb_clr) | issue_set;
    if (sb.flush) begin
      busy_d = '0;
    end
    if (R0_HARDWIRED) begin
      busy_d[0] = 1'b0;
    end
    wb_error_d = wb_error_q | wb_err_now;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      wb_error_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      wb_error_q <= wb_error_d;
    end
  end

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < 64; i++) begin
      busy_cnt = busy_cnt + {6'd0, busy_q[i]};
    end
  end

  assign sb.reg_busy   = busy_q | issue_set;
  assign sb.busy_count = busy_cnt;
  assign sb.idle       = (busy_cnt == 7'd0) && !sb.issue_valid;
  assign sb.wb_error   = wb_error_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: issue/writeback ordering, r0 handling, error flag, flush and reset.
module tb_reg_scoreboard;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  reg_scoreboard_if sb_if ();

  reg_scoreboard #(.R0_HARDWIRED(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    sb_if.issue_valid      = 1'b0;
    sb_if.issue_rd_rn      = 6'd0;
    sb_if.issue_rd2_rn     = 6'd0;
    sb_if.wb_alu1_valid    = 1'b0; sb_if.wb_alu1_rn    = 6'd0;
    sb_if.wb_alu2_valid    = 1'b0; sb_if.wb_alu2_rn    = 6'd0;
    sb_if.wb_memunit_valid = 1'b0; sb_if.wb_memunit_rn = 6'd0;
    sb_if.wb_branch_valid  = 1'b0; sb_if.wb_branch_rn  = 6'd0;
    sb_if.wb_advint_valid  = 1'b0; sb_if.wb_advint_rn  = 6'd0;
    sb_if.wb_advint2_valid = 1'b0; sb_if.wb_advint2_rn = 6'd0;
    sb_if.flush            = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] rd, input logic [5:0] rd2);
    sb_if.issue_valid  = 1'b1;
    sb_if.issue_rd_rn  = rd;
    sb_if.issue_rd2_rn = rd2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #12;
    n_vec++;
    if (sb_if.reg_busy !== 64'd0) begin
      n_err++; $display("FAIL reset_busy got %h want 0", sb_if.reg_busy);
    end
    n_vec++;
    if (sb_if.busy_count !== 7'd0) begin
      n_err++; $display("FAIL reset_count got %0d want 0", sb_if.busy_count);
    end
    n_vec++;
    if (sb_if.idle !== 1'b1) begin
      n_err++; $display("FAIL reset_idle got %b want 1", sb_if.idle);
    end
    n_vec++;
    if (sb_if.wb_error !== 1'b0) begin
      n_err++; $display("FAIL reset_wb_error got %b want 0", sb_if.wb_error);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_dual_issue();
    issue(6'd5, 6'd9);
    #1;
    n_vec++;
    if (sb_if.reg_busy[5] !== 1'b1 || sb_if.reg_busy[9] !== 1'b1) begin
      n_err++; $display("FAIL dual_same_cycle got r5=%b r9=%b want 1 1",
                        sb_if.reg_busy[5], sb_if.reg_busy[9]);
    end
    n_vec++;
    if (sb_if.idle !== 1'b0) begin
      n_err++; $display("FAIL dual_idle_issue got %b want 0", sb_if.idle);
    end
    step();
    idle_inputs();
    #1;
    n_vec++;
    if (sb_if.busy_count !== 7'd2) begin
      n_err++; $display("FAIL dual_count got %0d want 2", sb_if.busy_count);
    end
    n_vec++;
    if (sb_if.reg_busy !== 64'h0000_0000_0000_0220) begin
      n_err++; $display("FAIL dual_vector got %h want 0000000000000220", sb_if.reg_busy);
    end
    n_vec++;
    if (sb_if.idle !== 1'b0) begin
      n_err++; $display("FAIL dual_idle got %b want 0", sb_if.idle);
    end
  endtask

  task automatic test_wb_clear();
    sb_if.wb_alu1_valid = 1'b1;
    sb_if.wb_alu1_rn    = 6'd5;
    #1;
    n_vec++;
    if (sb_if.reg_busy[5] !== 1'b1) begin
      n_err++; $display("FAIL wb_same_cycle got %b want 1", sb_if.reg_busy[5]);
    end
    step();
    idle_inputs();
    #1;
    n_vec++;
    if (sb_if.reg_busy[5] !== 1'b0) begin
      n_err++; $display("FAIL wb_next_cycle got %b want 0", sb_if.reg_busy[5]);
    end
    n_vec++;
    if (sb_if.busy_count !== 7'd1) begin
      n_err++; $display("FAIL wb_count got %0d want 1", sb_if.busy_count);
    end
  endtask

  task automatic test_set_priority();
    issue(6'd7, 6'd0);
    step();
    // r7 busy: re-issue and writeback collide
    issue(6'd7, 6'd0);
    sb_if.wb_memunit_valid = 1'b1;
    sb_if.wb_memunit_rn    = 6'd7;
    step();
    idle_inputs();
    #1;
    n_vec++;
    if (sb_if.reg_busy[7] !== 1'b1) begin
      n_err++; $display("FAIL prio_busy7 got %b want 1", sb_if.reg_busy[7]);
    end
    n_vec++;
    if (sb_if.wb_error !== 1'b0) begin
      n_err++; $display("FAIL prio_error got %b want 0", sb_if.wb_error);
    end
    // r20 idle: issue plus writeback in the same cycle is not an error
    issue(6'd20, 6'd0);
    sb_if.wb_alu2_valid = 1'b1;
    sb_if.wb_alu2_rn    = 6'd20;
    step();
    idle_inputs();
    #1;
    n_vec++;
    if (sb_if.reg_busy[20] !== 1'b1 || sb_if.wb_error !== 1'b0) begin
      n_err++; $display("FAIL prio_idle_reg got busy=%b err=%b want 1 0",
                        sb_if.reg_busy[20], sb_if.wb_error);
    end
    // two ports writing back r9 together: one clear, no error
    sb_if.wb_alu1_valid   = 1'b1; sb_if.wb_alu1_rn   = 6'd9;
    sb_if.wb_branch_valid = 1'b1; sb_if.wb_branch_rn = 6'd9;
    step();
    idle_inputs();
    #1;
    n_vec++;
    if (sb_if.reg_busy !== 64'h0000_0000_0010_0080 || sb_if.wb_error !== 1'b0) begin
      n_err++; $display("FAIL dup_wb got %h err=%b want 0000000000100080 0",
                        sb_if.reg_busy, sb_if.wb_error);
    end
    n_vec++;
    if (sb_if.busy_count !== 7'd2) begin
      n_err++; $display("FAIL dup_wb_count got %0d want 2", sb_if.busy_count);
    end
  endtask

  task automatic test_r0();
    issue(6'd0, 6'd0);
    sb_if.wb_branch_valid = 1'b1;
    sb_if.wb_branch_rn    = 6'd0;
    #1;
    n_vec++;
    if (sb_if.reg_busy[0] !== 1'b0) begin
      n_err++; $display("FAIL r0_comb got %b want 0", sb_if.reg_busy[0]);
    end
    step();
    idle_inputs();
    #1;
    n_vec++;
    if (sb_if.busy_count !== 7'd2 || sb_if.reg_busy[0] !== 1'b0) begin
      n_err++; $display("FAIL r0_count got %0d r0=%b want 2 0",
                        sb_if.busy_count, sb_if.reg_busy[0]);
    end
    n_vec++;
    if (sb_if.wb_error !== 1'b0) begin
      n_err++; $display("FAIL r0_error got %b want 0", sb_if.wb_error);
    end
  endtask

  task automatic test_error_flush();
    sb_if.wb_alu2_valid = 1'b1;
    sb_if.wb_alu2_rn    = 6'd12;
    step();
    idle_inputs();
    #1;
    n_vec++;
    if (sb_if.wb_error !== 1'b1) begin
      n_err++; $display("FAIL err_set got %b want 1", sb_if.wb_error);
    end
    step();
    n_vec++;
    if (sb_if.wb_error !== 1'b1) begin
      n_err++; $display("FAIL err_sticky got %b want 1", sb_if.wb_error);
    end
    issue(6'd3, 6'd4);
    step();
    idle_inputs();
    #1;
    n_vec++;
    if (sb_if.busy_count !== 7'd4) begin
      n_err++; $display("FAIL pre_flush_count got %0d want 4", sb_if.busy_count);
    end
    // flush wins over a concurrent issue and writeback
    sb_if.flush = 1'b1;
    issue(6'd10, 6'd0);
    sb_if.wb_alu1_valid = 1'b1; sb_if.wb_alu1_rn = 6'd3;
    step();
    idle_inputs();
    #1;
    n_vec++;
    if (sb_if.busy_count !== 7'd0 || sb_if.reg_busy !== 64'd0) begin
      n_err++; $display("FAIL flush_clear got count=%0d busy=%h want 0 0",
                        sb_if.busy_count, sb_if.reg_busy);
    end
    n_vec++;
    if (sb_if.wb_error !== 1'b1) begin
      n_err++; $display("FAIL flush_error got %b want 1", sb_if.wb_error);
    end
    n_vec++;
    if (sb_if.idle !== 1'b1) begin
      n_err++; $display("FAIL flush_idle got %b want 1", sb_if.idle);
    end
  endtask

  task automatic test_six_wb();
    issue(6'd1, 6'd2); step();
    issue(6'd3, 6'd4); step();
    issue(6'd5, 6'd6); step();
    idle_inputs();
    #1;
    n_vec++;
    if (sb_if.busy_count !== 7'd6 || sb_if.reg_busy !== 64'h0000_0000_0000_007E) begin
      n_err++; $display("FAIL six_setup got count=%0d busy=%h want 6 000000000000007e",
                        sb_if.busy_count, sb_if.reg_busy);
    end
    sb_if.wb_alu1_valid    = 1'b1; sb_if.wb_alu1_rn    = 6'd1;
    sb_if.wb_alu2_valid    = 1'b1; sb_if.wb_alu2_rn    = 6'd2;
    sb_if.wb_memunit_valid = 1'b1; sb_if.wb_memunit_rn = 6'd3;
    sb_if.wb_branch_valid  = 1'b1; sb_if.wb_branch_rn  = 6'd4;
    sb_if.wb_advint_valid  = 1'b1; sb_if.wb_advint_rn  = 6'd5;
    sb_if.wb_advint2_valid = 1'b1; sb_if.wb_advint2_rn = 6'd6;
    step();
    idle_inputs();
    #1;
    n_vec++;
    if (sb_if.busy_count !== 7'd0 || sb_if.reg_busy !== 64'd0) begin
      n_err++; $display("FAIL six_clear got count=%0d busy=%h want 0 0",
                        sb_if.busy_count, sb_if.reg_busy);
    end
  endtask

  task automatic test_reset_mid();
    issue(6'd8, 6'd0);
    step();
    issue(6'd11, 6'd0);
    #2;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    n_vec++;
    if (sb_if.reg_busy !== 64'd0 || sb_if.busy_count !== 7'd0) begin
      n_err++; $display("FAIL mid_reset_state got busy=%h count=%0d want 0 0",
                        sb_if.reg_busy, sb_if.busy_count);
    end
    n_vec++;
    if (sb_if.idle !== 1'b1 || sb_if.wb_error !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_flags got idle=%b err=%b want 1 0",
                        sb_if.idle, sb_if.wb_error);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(6'd13, 6'd0);
    step();
    idle_inputs();
    #1;
    n_vec++;
    if (sb_if.busy_count !== 7'd1 || sb_if.reg_busy !== 64'h0000_0000_0000_2000) begin
      n_err++; $display("FAIL post_reset_resume got count=%0d busy=%h want 1 0000000000002000",
                        sb_if.busy_count, sb_if.reg_busy);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_dual_issue();
    test_wb_clear();
    test_set_priority();
    test_r0();
    test_error_flush();
    test_six_wb();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
